matrix_scan_driver: RTL and testbench
=====================================

// Module: matrix_scan_driver
// PURPOSE
//   Parametrised multiplexed LED-matrix scanner; next generation of the fixed 4x4 display scan.
//   Drives ROWS one-cold row lines and COLS column lines from a flat pixel vector.
//   Adds per-row blanking (anti-ghosting), PWM brightness, frame-latched (tear-free) pixel data,
//   an enable/freeze control and a frame-start strobe. Sits between the clock counters and pins.
// PARAMETERS
//   ROWS        4  number of multiplexed rows (>=2)
//   COLS        4  number of columns (>=1)
//   DWELL       8  clk cycles per row slot, blank cycles included (> BLANK)
//   BLANK       1  cycles at start of each slot with all lines off (>=0)
//   BRIGHT_BITS 3  width of brightness input
// PORTS
//   clk         in   1              system clock, all flops on posedge
//   rst         in   1              synchronous reset, active-high
//   en          in   1              1 = scan; 0 = blank outputs and freeze scan position
//   pixels      in   ROWS*COLS      pixel[r*COLS+c] lights row r, column c (1 = on)
//   brightness  in   BRIGHT_BITS    lit cycles per slot; >= DWELL-BLANK means full on
//   rows        out  ROWS           active-low row select, one-cold when driving
//   cols        out  COLS           active-high column data
//   row_idx     out  clog2(ROWS)    row currently selected
//   frame_start out  1              1-cycle strobe on first cycle of each frame
// BEHAVIOUR
// - Reset (rst=1 at an edge): rows=all 1, cols=0, row_idx=0, frame_start=0 after that edge;
//   internal slot counter d=0, row r=0; shadow pixels/brightness load from inputs each reset edge.
// - All outputs are driven straight from flops; no combinational input->output path.
// - Cycle k = k-th cycle with en=1 since rst released (k=0 first). d=k mod DWELL;
//   r=(k/DWELL) mod ROWS. Frame period = ROWS*DWELL cycles.
// - Output in cycle k: row_idx=r.
//     d <  BLANK:           rows=all 1, cols=0.
//     d >= BLANK:           rows bit r=0, others 1;
//                           cols = shadow row r if (d-BLANK) < min(bright_sh, DWELL-BLANK), else 0.
//   brightness 0 -> cols always 0, rows still scanned.
// - frame_start=1 exactly in cycles with r=0, d=0 (incl. k=0); otherwise 0.
// - Shadow load: on the edge entering r=0,d=0 (r=ROWS-1, d=DWELL-1, en=1) and on reset edges.
//   Input changes mid-frame never alter the current frame.
// - d wraps DWELL-1 -> 0 advancing r; r wraps ROWS-1 -> 0. No other wrap values.
// - en=0 at an edge: counters hold, next cycle rows=all 1, cols=0, frame_start=0, row_idx held;
//   no shadow load. en back to 1: resume at held (r,d) with its normal outputs.
// - rst has priority over en; reset mid-frame aborts frame, restart at k=0 after release.
// - BLANK=0: no dark cycles; row change is direct. Counters sized clog2(DWELL), clog2(ROWS).
// TESTING (ROWS=4 COLS=4 DWELL=8 BLANK=1 BRIGHT_BITS=3 unless noted)
// - rst held 5 cycles, random pixels -> rows=4'b1111, cols=0, frame_start=0, row_idx=0 throughout.
// - pixels=16'h8421, brightness=7, en=1 -> k0: frame_start=1, rows=1111, cols=0; k1-7 rows=1110
//   cols=0001; k9-15 rows=1101 cols=0010; k25-31 rows=0111 cols=1000; frame_start again k32.
// - brightness=3, pixels=16'hFFFF -> each slot: d1-3 cols=1111, d4-7 cols=0 with row still low;
//   brightness=0 -> cols=0 every cycle, rows still scan.
// - pixels 16'h0001 -> 16'h0002 at k10 -> k11-15 still show old shadow; new data
//   (row0 cols=0010) first at k33.
// - en=0 for cycles k12..k16 -> rows=1111 cols=0 those cycles; resume row1 d=4 at next en=1;
//   next frame_start 5 cycles late (cycle 37).
// - rst pulsed 1 cycle at cycle 20 -> cycle 21 outputs off; after release frame_start=1, row0 blank.
// - ROWS=8 COLS=5 DWELL=4 BLANK=0 -> frame period 32, rows one-cold every cycle,
//   row_idx 0..7 wraps to 0.

Source files
------------

// File: rtl/matrix_scan_driver_if.sv
// matrix_scan_driver_if: control, pixel and pin-side signals of the LED-matrix scanner
interface matrix_scan_driver_if #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int BRIGHT_BITS = 3
);
  localparam int RW = $clog2(ROWS);
  logic                   en;
  logic [ROWS*COLS-1:0]   pixels;
  logic [BRIGHT_BITS-1:0] brightness;
  logic [ROWS-1:0]        rows;
  logic [COLS-1:0]        cols;
  logic [RW-1:0]          row_idx;
  logic                   frame_start;
  modport master (output en, pixels, brightness, input rows, cols, row_idx, frame_start);
  modport slave  (input en, pixels, brightness, output rows, cols, row_idx, frame_start);
endinterface

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: multiplexed LED-matrix scanner with blanking, PWM and frame-latched pixels
module matrix_scan_driver #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DWELL       = 8,
  parameter int BLANK       = 1,
  parameter int BRIGHT_BITS = 3
) (
  input logic                clk,
  input logic                rst,
  matrix_scan_driver_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [DW-1:0]          r_d;
  logic [RW-1:0]          r_r;
  logic [ROWS*COLS-1:0]   r_pix;
  logic [BRIGHT_BITS-1:0] r_bright;
  logic [ROWS-1:0]        r_rows;
  logic [COLS-1:0]        r_cols;
  logic [RW-1:0]          r_idx;
  logic                   r_fs;
  logic                   w_d_last, w_r_last, w_on, w_lit;
  logic [ROWS-1:0]        w_rows;
  logic [COLS-1:0]        w_cols;
  // outputs are registered from the current slot, so each cycle shows the slot of the previous edge
  always_comb begin
    w_d_last = r_d == DW'(DWELL - 1);
    w_r_last = r_r == RW'(ROWS - 1);
    w_on     = int'(r_d) >= BLANK;
    w_lit    = w_on && (int'(r_d) - BLANK < int'(r_bright));
    w_rows   = w_on ? ~(ROWS'(1) << r_r) : '1;
    w_cols   = w_lit ? r_pix[r_r*COLS +: COLS] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d      <= '0;
      r_r      <= '0;
      r_pix    <= bus.pixels;
      r_bright <= bus.brightness;
      r_rows   <= '1;
      r_cols   <= '0;
      r_idx    <= '0;
      r_fs     <= 1'b0;
    end else if (!bus.en) begin
      r_rows <= '1;
      r_cols <= '0;
      r_fs   <= 1'b0;
    end else begin
      r_rows <= w_rows;
      r_cols <= w_cols;
      r_idx  <= r_r;
      r_fs   <= (r_r == '0) && (r_d == '0);
      r_d    <= w_d_last ? '0 : r_d + 1'b1;
      if (w_d_last) r_r <= w_r_last ? '0 : r_r + 1'b1;
      if (w_d_last && w_r_last) begin
        r_pix    <= bus.pixels;
        r_bright <= bus.brightness;
      end
    end
  end
  assign bus.rows        = r_rows;
  assign bus.cols        = r_cols;
  assign bus.row_idx     = r_idx;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver: directed checks of the 4x4 and 8x5 scanner configurations
module tb_matrix_scan_driver;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  matrix_scan_driver_if #(.ROWS(4), .COLS(4), .BRIGHT_BITS(3)) a_if();
  matrix_scan_driver_if #(.ROWS(8), .COLS(5), .BRIGHT_BITS(3)) b_if();
  matrix_scan_driver #(.ROWS(4), .COLS(4), .DWELL(8), .BLANK(1), .BRIGHT_BITS(3))
    dut_a (.clk(clk), .rst(rst_a), .bus(a_if));
  matrix_scan_driver #(.ROWS(8), .COLS(5), .DWELL(4), .BLANK(0), .BRIGHT_BITS(3))
    dut_b (.clk(clk), .rst(rst_b), .bus(b_if));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask
  task automatic chk_off_a(input string tag, input logic [1:0] idx);
    chk({tag, "_rows"}, -1, a_if.rows, 4'hF);
    chk({tag, "_cols"}, -1, a_if.cols, 4'h0);
    chk({tag, "_fs"}, -1, a_if.frame_start, 1'b0);
    chk({tag, "_idx"}, -1, a_if.row_idx, idx);
  endtask
  task automatic chk_a(input int k, input logic [15:0] p, input int b);
    int d, r, lim;
    logic [3:0] er, ec;
    logic [1:0] ei;
    logic ef;
    d   = k % 8;
    r   = (k / 8) % 4;
    lim = b < 7 ? b : 7;
    er  = d < 1 ? 4'hF : ~(4'b0001 << r);
    ec  = (d >= 1 && d - 1 < lim) ? p[r*4 +: 4] : 4'h0;
    ei  = 2'(r);
    ef  = d == 0 && r == 0;
    chk("a_rows", k, a_if.rows, er);
    chk("a_cols", k, a_if.cols, ec);
    chk("a_idx", k, a_if.row_idx, ei);
    chk("a_fs", k, a_if.frame_start, ef);
  endtask
  task automatic run_a(input int from, input int to, input logic [15:0] p, input int b);
    for (int k = from; k <= to; k++) begin
      tick();
      chk_a(k, p, b);
    end
  endtask
  task automatic reset_a(input int n, input logic [15:0] p, input logic [2:0] b);
    rst_a = 1'b1;
    for (int i = 0; i < n; i++) begin
      a_if.pixels     = (i == n - 1) ? p : 16'($urandom);
      a_if.brightness = b;
      tick();
      chk_off_a("rst", 2'd0);
    end
    rst_a = 1'b0;
  endtask
  initial begin
    logic [39:0] pb;
    a_if.en = 1'b1;
    a_if.pixels = '0;
    a_if.brightness = '0;
    b_if.en = 1'b1;
    b_if.pixels = '0;
    b_if.brightness = 3'd7;
    // basic scan of 16'h8421 at full brightness
    reset_a(5, 16'h8421, 3'd7);
    run_a(0, 0, 16'h8421, 7);
    chk("lit_k0_fs", 0, a_if.frame_start, 1'b1);
    chk("lit_k0_rows", 0, a_if.rows, 4'hF);
    run_a(1, 1, 16'h8421, 7);
    chk("lit_k1_rows", 1, a_if.rows, 4'hE);
    chk("lit_k1_cols", 1, a_if.cols, 4'h1);
    run_a(2, 9, 16'h8421, 7);
    chk("lit_k9_rows", 9, a_if.rows, 4'hD);
    chk("lit_k9_cols", 9, a_if.cols, 4'h2);
    run_a(10, 25, 16'h8421, 7);
    chk("lit_k25_rows", 25, a_if.rows, 4'h7);
    chk("lit_k25_cols", 25, a_if.cols, 4'h8);
    run_a(26, 32, 16'h8421, 7);
    chk("lit_k32_fs", 32, a_if.frame_start, 1'b1);
    // partial brightness, then brightness 0 taking effect only at next frame
    reset_a(1, 16'hFFFF, 3'd3);
    run_a(0, 3, 16'hFFFF, 3);
    chk("lit_b3_d3", 3, a_if.cols, 4'hF);
    run_a(4, 4, 16'hFFFF, 3);
    chk("lit_b3_d4_cols", 4, a_if.cols, 4'h0);
    chk("lit_b3_d4_rows", 4, a_if.rows, 4'hE);
    run_a(5, 20, 16'hFFFF, 3);
    a_if.brightness = 3'd0;
    run_a(21, 31, 16'hFFFF, 3);
    run_a(32, 63, 16'hFFFF, 0);
    // mid-frame pixel change is held off until the next frame
    reset_a(1, 16'h0001, 3'd7);
    run_a(0, 10, 16'h0001, 7);
    a_if.pixels = 16'h0002;
    run_a(11, 31, 16'h0001, 7);
    run_a(32, 33, 16'h0002, 7);
    chk("lit_k33_cols", 33, a_if.cols, 4'h2);
    run_a(34, 40, 16'h0002, 7);
    // enable low for five edges freezes the scan position
    reset_a(1, 16'h8421, 3'd7);
    run_a(0, 11, 16'h8421, 7);
    a_if.en = 1'b0;
    repeat (5) begin
      tick();
      chk_off_a("en_off", 2'd1);
    end
    a_if.en = 1'b1;
    run_a(12, 12, 16'h8421, 7);
    chk("lit_resume_rows", 12, a_if.rows, 4'hD);
    chk("lit_resume_cols", 12, a_if.cols, 4'h2);
    run_a(13, 32, 16'h8421, 7);
    chk("lit_late_fs", 32, a_if.frame_start, 1'b1);
    // one-cycle reset mid-frame restarts at k=0
    reset_a(1, 16'h8421, 3'd7);
    run_a(0, 19, 16'h8421, 7);
    rst_a = 1'b1;
    tick();
    chk_off_a("midrst", 2'd0);
    rst_a = 1'b0;
    run_a(0, 1, 16'h8421, 7);
    // 8x5, DWELL=4, BLANK=0 configuration
    pb = 40'hA5_3C_96_E1_7B;
    b_if.pixels = pb;
    tick();
    rst_b = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      int d, r;
      logic [7:0] er;
      logic [4:0] ec;
      logic [2:0] ei;
      logic ef;
      tick();
      d  = k % 4;
      r  = (k / 4) % 8;
      er = ~(8'h01 << r);
      ec = pb[r*5 +: 5];
      ei = 3'(r);
      ef = d == 0 && r == 0;
      chk("b_rows", k, b_if.rows, er);
      chk("b_cols", k, b_if.cols, ec);
      chk("b_idx", k, b_if.row_idx, ei);
      chk("b_fs", k, b_if.frame_start, ef);
    end
    chk("lit_b_idx_wrap", 64, b_if.row_idx, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
